uart_ram_loader: RTL and testbench

//  Software-upgrade loader. Consumes received UART bytes, parses a framed image and writes it word-by-word

---
 rtl/uart_ram_loader.sv | 184 ++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: parses a framed software image arriving as UART bytes
// (sync, 16-bit word count, little-endian payload words, 8-bit payload sum)
// and writes it word-by-word into RAM while holding the core in reset.
module uart_ram_loader #(
  parameter int         XLEN         = 32,
  parameter int         RAM_ADDR_LEN = 14,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC  = 5000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_uart_upgrade_b,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    during_sw_upgrade,
  output logic                    uart_ram_wr_en,
  output logic [RAM_ADDR_LEN-1:0] uart_ram_addr,
  output logic [XLEN-1:0]         uart_ram_wr_data,
  output logic [XLEN/8-1:0]       uart_ram_we,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int              BYTES     = XLEN / 8;
  localparam int              BW        = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(64'd1 << RAM_ADDR_LEN);
  localparam logic [BW-1:0]   LAST_BYTE = BW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    LEN_LO = 3'd2,
    LEN_HI = 3'd3,
    DATA   = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  state_t          state;
  logic            req_meta;
  logic            req;
  logic [15:0]     n;
  logic [15:0]     n_full;
  logic [15:0]     word_idx;
  logic [BW-1:0]   byte_idx;
  logic [XLEN-9:0] data_buf;
  logic [7:0]      csum;
  logic [TW-1:0]   tcnt;

  // Full word count as seen while the high length byte is on rx_data.
  always_comb begin
    n_full = {rx_data, n[7:0]};
  end

  // Two-flop synchroniser for the asynchronous, active-low upgrade request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta <= 1'b0;
      req      <= 1'b0;
    end else begin
      req_meta <= ~sw_uart_upgrade_b;
      req      <= req_meta;
    end
  end

  // Frame parser FSM with registered RAM-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      during_sw_upgrade <= 1'b0;
      uart_ram_wr_en    <= 1'b0;
      uart_ram_addr     <= '0;
      uart_ram_wr_data  <= '0;
      uart_ram_we       <= '0;
      load_done         <= 1'b0;
      load_err          <= 1'b0;
      n                 <= 16'd0;
      word_idx          <= 16'd0;
      byte_idx          <= '0;
      data_buf          <= '0;
      csum              <= 8'd0;
      tcnt              <= '0;
    end else begin
      // Write strobe and byte enables are single-cycle pulses.
      uart_ram_wr_en <= 1'b0;
      uart_ram_we    <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            state             <= SYNC;
            during_sw_upgrade <= 1'b1;
            load_done         <= 1'b0;
            load_err          <= 1'b0;
          end
        end
        SYNC: begin
          // Hunting for the marker never times out; an abort here is not an error.
          if (!req) begin
            state             <= IDLE;
            during_sw_upgrade <= 1'b0;
          end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state    <= LEN_LO;
            tcnt     <= '0;
            csum     <= 8'd0;
            word_idx <= 16'd0;
            byte_idx <= '0;
          end
        end
        DONE, ERR: begin
          if (!req) begin
            state             <= IDLE;
            during_sw_upgrade <= 1'b0;
          end
        end
        default: begin
          // LEN_LO, LEN_HI, DATA, CSUM: abort beats any pending write, and a
          // byte arriving on the expiry cycle beats the timeout.
          if (!req) begin
            state             <= IDLE;
            during_sw_upgrade <= 1'b0;
            load_err          <= 1'b1;
          end else if (rx_valid) begin
            tcnt <= '0;
            case (state)
              LEN_LO: begin
                n[7:0] <= rx_data;
                state  <= LEN_HI;
              end
              LEN_HI: begin
                n[15:8] <= rx_data;
                if ({1'b0, n_full} > MAX_WORDS) begin
                  state    <= ERR;
                  load_err <= 1'b1;
                end else if (n_full == 16'd0) begin
                  state <= CSUM;
                end else begin
                  state <= DATA;
                end
              end
              DATA: begin
                csum <= csum + rx_data;
                if (byte_idx == LAST_BYTE) begin
                  uart_ram_wr_en   <= 1'b1;
                  uart_ram_we      <= {BYTES{1'b1}};
                  uart_ram_addr    <= word_idx[RAM_ADDR_LEN-1:0];
                  uart_ram_wr_data <= {rx_data, data_buf};
                  byte_idx         <= '0;
                  word_idx         <= word_idx + 16'd1;
                  if (word_idx == (n - 16'd1)) begin
                    state <= CSUM;
                  end
                end else begin
                  data_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                  byte_idx                          <= byte_idx + BW'(1);
                end
              end
              CSUM: begin
                if (rx_data == csum) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
                end
              end
              default: begin
                state <= state;
              end
            endcase
          end else if (tcnt == T_LAST) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader: a table of complete frames plus
// hand-written sequences for timeout, maximum length, abort and reset.
module tb_uart_ram_loader;

  localparam int RAL = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sw_uart_upgrade_b = 1'b1;
  logic           rx_valid = 1'b0;
  logic [7:0]     rx_data = 8'd0;
  logic           during_sw_upgrade;
  logic           uart_ram_wr_en;
  logic [RAL-1:0] uart_ram_addr;
  logic [31:0]    uart_ram_wr_data;
  logic [3:0]     uart_ram_we;
  logic           load_done;
  logic           load_err;

  int total = 0;
  int bad = 0;
  int nwr = 0;
  logic [RAL-1:0] log_addr [32];
  logic [31:0]    log_data [32];

  uart_ram_loader #(
    .XLEN(32), .RAM_ADDR_LEN(RAL), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .sw_uart_upgrade_b(sw_uart_upgrade_b),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .during_sw_upgrade(during_sw_upgrade), .uart_ram_wr_en(uart_ram_wr_en),
    .uart_ram_addr(uart_ram_addr), .uart_ram_wr_data(uart_ram_wr_data),
    .uart_ram_we(uart_ram_we), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              nbytes;
    logic [0:15][7:0] bytes;
    int              nwr;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic            done;
    logic            err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture every write strobe seen between clock edges.
  always @(negedge clk) begin
    if (uart_ram_wr_en === 1'b1) begin
      check("we_all_ones", {28'd0, uart_ram_we}, 32'hF);
      if (nwr < 32) begin
        log_addr[nwr] = uart_ram_addr;
        log_data[nwr] = uart_ram_wr_data;
      end
      nwr++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_req();
    sw_uart_upgrade_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic stop_req();
    sw_uart_upgrade_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Payload 11..88 sums to 0x264, so the matching checksum byte is 0x64.
    vecs[0] = '{12, 128'hA5_02_00_11_22_33_44_55_66_77_88_64_00_00_00_00, 2, 32'h44332211, 32'h88776655, 1'b1, 1'b0};
    vecs[1] = '{12, 128'hA5_02_00_11_22_33_44_55_66_77_88_00_00_00_00_00, 2, 32'h44332211, 32'h88776655, 1'b0, 1'b1};
    vecs[2] = '{15, 128'h00_FF_5A_A5_02_00_11_22_33_44_55_66_77_88_64_00, 2, 32'h44332211, 32'h88776655, 1'b1, 1'b0};
    vecs[3] = '{4,  128'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{4,  128'hA5_00_00_01_00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[5] = '{3,  128'hA5_11_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    // DE+AD+BE+EF = 0x338 -> checksum 0x38.
    vecs[6] = '{8,  128'hA5_01_00_DE_AD_BE_EF_38_00_00_00_00_00_00_00_00, 1, 32'hEFBEADDE, 32'h0, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_during", {31'd0, during_sw_upgrade}, 32'd0);
    check("rst_wr_en", {31'd0, uart_ram_wr_en}, 32'd0);
    check("rst_we", {28'd0, uart_ram_we}, 32'd0);
    check("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table of complete frames.
    for (int i = 0; i < 7; i++) begin
      nwr = 0;
      start_req();
      check($sformatf("v%0d_during_on", i), {31'd0, during_sw_upgrade}, 32'd1);
      check($sformatf("v%0d_cleared", i), {30'd0, load_done, load_err}, 32'd0);
      for (int b = 0; b < vecs[i].nbytes; b++) send_byte(vecs[i].bytes[b]);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_nwr", i), nwr, vecs[i].nwr);
      if (vecs[i].nwr > 0) begin
        check($sformatf("v%0d_addr0", i), {28'd0, log_addr[0]}, 32'd0);
        check($sformatf("v%0d_w0", i), log_data[0], vecs[i].w0);
      end
      if (vecs[i].nwr > 1) begin
        check($sformatf("v%0d_addr1", i), {28'd0, log_addr[1]}, 32'd1);
        check($sformatf("v%0d_w1", i), log_data[1], vecs[i].w1);
      end
      check($sformatf("v%0d_done", i), {31'd0, load_done}, {31'd0, vecs[i].done});
      check($sformatf("v%0d_err", i), {31'd0, load_err}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_during_held", i), {31'd0, during_sw_upgrade}, 32'd1);
      stop_req();
      check($sformatf("v%0d_during_off", i), {31'd0, during_sw_upgrade}, 32'd0);
      check($sformatf("v%0d_sticky", i), {30'd0, load_done, load_err}, {30'd0, vecs[i].done, vecs[i].err});
    end

    // Timeout: no timeout while hunting for sync, then exactly 100 idle cycles.
    nwr = 0;
    start_req();
    repeat (150) @(negedge clk);
    check("sync_no_timeout", {31'd0, load_err}, 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    repeat (99) @(negedge clk);
    check("timeout_early", {31'd0, load_err}, 32'd0);
    @(negedge clk);
    check("timeout_exact", {31'd0, load_err}, 32'd1);
    check("timeout_no_write", nwr, 0);
    stop_req();

    // Largest image: 16 words fill addresses 0..15.
    begin
      logic [7:0]  sum;
      logic [7:0]  b;
      logic [31:0] w;
      nwr = 0;
      sum = 8'd0;
      start_req();
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
      for (int k = 0; k < 16; k++) begin
        for (int j = 0; j < 4; j++) begin
          b = 8'(k * 7 + j * 3 + 1);
          sum = sum + b;
          send_byte(b);
        end
      end
      send_byte(sum);
      repeat (3) @(negedge clk);
      check("max_nwr", nwr, 16);
      for (int k = 0; k < 16; k++) begin
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(k * 7 + j * 3 + 1);
        check($sformatf("max_addr%0d", k), {28'd0, log_addr[k]}, k);
        check($sformatf("max_data%0d", k), log_data[k], w);
      end
      check("max_done", {30'd0, load_done, load_err}, 32'd2);
      stop_req();
    end

    // Abort from SYNC is not an error.
    start_req();
    stop_req();
    check("abort_sync", {30'd0, load_done, load_err}, 32'd0);

    // Abort after two payload bytes: IDLE one cycle after the synchronised drop.
    nwr = 0;
    start_req();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    sw_uart_upgrade_b = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_still_busy", {31'd0, during_sw_upgrade}, 32'd1);
    @(negedge clk);
    check("abort_idle", {31'd0, during_sw_upgrade}, 32'd0);
    check("abort_err", {30'd0, load_done, load_err}, 32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_write", nwr, 0);

    // Reset mid-payload clears outputs without waiting for a clock edge.
    start_req();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_during", {31'd0, during_sw_upgrade}, 32'd0);
    check("rst_mid_outs", {26'd0, uart_ram_wr_en, uart_ram_we, load_done}, 32'd0);
    sw_uart_upgrade_b = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_after", {30'd0, during_sw_upgrade, load_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
